irq_ctrl: RTL and testbench

Machine-mode interrupt source for the pipelined core; the initiating end of the `interrupt` line into the exception unit. It holds a 32-bit machine timer (mtime/mtimecmp) and N edge-triggered external interrupt lines, plus pending and enable registers. It presents one prioritised request with a cause code, and tracks the request through an acknowledge/return handshake. Registers are memory-mapped on the data-side bus next to the other MMIO peripherals.

---
 rtl/irq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine timer plus N_EXT edge-triggered lines, prioritised into a single
// request tracked through ack/done. Define IRQ_TIMER_EN to build the mtime/mtimecmp timer.
module irq_ctrl #(
  parameter int          N_EXT     = 4,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_EXT-1:0] ext_irq,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic             bus_we,
  input  logic             bus_re,
  output logic [31:0]      bus_rdata,
  output logic             irq_req,
  output logic [31:0]      irq_cause,
  output logic [3:0]       irq_id,
  input  logic             irq_ack,
  input  logic             irq_done
);
  localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state;

  logic             hit, wr_mtime, wr_cmp, wr_pend, wr_en, ack_ext;
  logic [N_EXT-1:0] sync1, sync2, sync_d, ext_rise, ext_pend, ext_en, ext_act, ext_clr;
  logic             tmr_pend, tmr_en;
  logic [31:0]      mtime_rd, cmp_rd, rd_val;
  logic             win_valid, any_src;
  logic [3:0]       win_id;

  assign hit      = (bus_addr[31:4] == BASE_ADDR[31:4]) && (bus_addr[1:0] == 2'b00);
  assign wr_mtime = bus_we && hit && (bus_addr[3:2] == 2'd0);
  assign wr_cmp   = bus_we && hit && (bus_addr[3:2] == 2'd1);
  assign wr_pend  = bus_we && hit && (bus_addr[3:2] == 2'd2);
  assign wr_en    = bus_we && hit && (bus_addr[3:2] == 2'd3);

`ifdef IRQ_TIMER_EN
  logic [31:0] mtime, mtimecmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime    <= '0;
      mtimecmp <= '1;
      tmr_en   <= 1'b0;
    end else begin
      mtime <= wr_mtime ? bus_wdata : mtime + 32'd1;
      if (wr_cmp) mtimecmp <= bus_wdata;
      if (wr_en)  tmr_en   <= bus_wdata[31];
    end
  end

  // Level-sensitive and combinational so the FSM sees it in the same cycle
  assign tmr_pend = (mtime >= mtimecmp);
  assign mtime_rd = mtime;
  assign cmp_rd   = mtimecmp;
`else
  logic unused_timer;
  assign unused_timer = ^{wr_mtime, wr_cmp, bus_wdata};
  assign tmr_pend     = 1'b0;
  assign tmr_en       = 1'b0;
  assign mtime_rd     = '0;
  assign cmp_rd       = '0;
`endif

  // Two synchroniser stages, then a delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      sync_d <= '0;
    end else begin
      sync1  <= ext_irq;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign ext_rise = sync2 & ~sync_d;
  assign ext_act  = ext_pend & ext_en;
  assign ack_ext  = (state == REQ) && irq_ack && (irq_cause == CAUSE_EXT);

  always_comb begin
    ext_clr = '0;
    if (wr_pend) ext_clr = bus_wdata[N_EXT-1:0];
    for (int i = 0; i < N_EXT; i++)
      if (ack_ext && (irq_id == 4'(i))) ext_clr[i] = 1'b1;
  end

  // Clearing is applied before setting so a coincident edge is never lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_pend <= '0;
      ext_en   <= '0;
    end else begin
      ext_pend <= (ext_pend & ~ext_clr) | ext_rise;
      if (wr_en) ext_en <= bus_wdata[N_EXT-1:0];
    end
  end

  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int i = N_EXT - 1; i >= 0; i--) begin
      if (ext_act[i]) begin
        win_valid = 1'b1;
        win_id    = 4'(i);
      end
    end
  end

  assign any_src = win_valid | (tmr_pend & tmr_en);

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (bus_addr[3:2])
        2'd0: rd_val = mtime_rd;
        2'd1: rd_val = cmp_rd;
        2'd2: begin
          rd_val[N_EXT-1:0] = ext_pend;
          rd_val[31]        = tmr_pend;
        end
        default: begin
          rd_val[N_EXT-1:0] = ext_en;
          rd_val[31]        = tmr_en;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bus_rdata <= '0;
    else if (bus_re) bus_rdata <= rd_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irq_req   <= 1'b0;
      irq_cause <= '0;
      irq_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_src) begin
            state     <= REQ;
            irq_req   <= 1'b1;
            irq_cause <= win_valid ? CAUSE_EXT : CAUSE_TMR;
            irq_id    <= win_id;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state   <= SERVICE;
            irq_req <= 1'b0;
          end else if (!any_src) begin
            state   <= IDLE;
            irq_req <= 1'b0;
          end
        end
        SERVICE: begin
          if (irq_done) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised and directed bench for irq_ctrl against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_irq_ctrl;
  localparam int          N     = 4;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] C_EXT = 32'h8000_000B;
  localparam logic [31:0] C_TMR = 32'h8000_0007;
`ifdef IRQ_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif
  localparam logic [31:0] EN_MASK = (TIMER_ON ? 32'h8000_0000 : 32'h0) | ((32'd1 << N) - 32'd1);

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]  ext_irq = '0;
  logic [31:0]   bus_addr = '0, bus_wdata = '0;
  logic          bus_we = 1'b0, bus_re = 1'b0, irq_ack = 1'b0, irq_done = 1'b0;
  logic [31:0]   bus_rdata, irq_cause;
  logic          irq_req;
  logic [3:0]    irq_id;
  int            checks = 0, errors = 0;
  logic [31:0]   rd;

  irq_ctrl #(.N_EXT(N), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .ext_irq(ext_irq),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .irq_req(irq_req), .irq_cause(irq_cause), .irq_id(irq_id),
    .irq_ack(irq_ack), .irq_done(irq_done)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 = waiting, 1 = requesting, 2 = in handler
  logic [31:0]  m_mtime, m_cmp, m_en, m_rdata, m_cause;
  logic [N-1:0] m_pend, h0, h1, h2;
  logic [3:0]   m_id;
  logic         m_req;
  int           m_phase;

  task automatic modelReset();
    m_mtime = 0; m_cmp = 32'hFFFF_FFFF; m_en = 0; m_rdata = 0; m_cause = 0;
    m_pend = '0; h0 = '0; h1 = '0; h2 = '0; m_id = 0; m_req = 0; m_phase = 0;
  endtask

  function automatic logic [31:0] regRead(logic [31:0] a, logic tp);
    if ((a & 32'hFFFF_FFF3) != BASE) return 32'h0;
    case (a[3:2])
      2'd0:    return TIMER_ON ? m_mtime : 32'h0;
      2'd1:    return TIMER_ON ? m_cmp : 32'h0;
      2'd2:    return {tp, 31'(m_pend)};
      default: return m_en;
    endcase
  endfunction

  task automatic modelStep();
    logic tp, any_src;
    logic [N-1:0] np;
    int win;
    logic wr_hit;
    tp = TIMER_ON && (m_mtime >= m_cmp);
    win = -1;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) win = i;
    any_src = (win >= 0) || (tp && m_en[31]);
    if (bus_re) m_rdata = regRead(bus_addr, tp);
    wr_hit = bus_we && ((bus_addr & 32'hFFFF_FFF3) == BASE);
    np = m_pend;
    if (wr_hit && bus_addr[3:2] == 2'd2) np = np & ~bus_wdata[N-1:0];
    if (m_phase == 1 && irq_ack && m_cause == C_EXT) np = np & ~(N'(1) << m_id);
    np = np | (h1 & ~h2);
    case (m_phase)
      0: if (any_src) begin
        m_phase = 1; m_req = 1;
        m_cause = (win >= 0) ? C_EXT : C_TMR;
        m_id    = (win >= 0) ? 4'(win) : 4'd0;
      end
      1: if (irq_ack) begin m_phase = 2; m_req = 0; end
         else if (!any_src) begin m_phase = 0; m_req = 0; end
      default: if (irq_done) m_phase = 0;
    endcase
    m_pend = np;
    if (TIMER_ON) begin
      m_mtime = (wr_hit && bus_addr[3:2] == 2'd0) ? bus_wdata : m_mtime + 1;
      if (wr_hit && bus_addr[3:2] == 2'd1) m_cmp = bus_wdata;
    end
    if (wr_hit && bus_addr[3:2] == 2'd3) m_en = bus_wdata & EN_MASK;
    h2 = h1; h1 = h0; h0 = ext_irq;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk); #1;
    checkOutput("irq_req",   32'(irq_req), 32'(m_req));
    checkOutput("irq_cause", irq_cause,    m_cause);
    checkOutput("irq_id",    32'(irq_id),  32'(m_id));
    checkOutput("bus_rdata", bus_rdata,    m_rdata);
  end

  task automatic cyc(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic busWrite(logic [31:0] a, logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    cyc();
    bus_we = 1'b0;
  endtask

  task automatic busRead(logic [31:0] a, output logic [31:0] d);
    bus_addr = a; bus_re = 1'b1;
    cyc();
    bus_re = 1'b0;
    d = bus_rdata;
  endtask

  task automatic waitReq(string what, int budget);
    int n = 0;
    while (!irq_req && n < budget) begin cyc(); n++; end
    checkOutput(what, 32'(irq_req), 32'd1);
  endtask

  task automatic serviceReq(string what);
    waitReq(what, 20);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    irq_done = 1'b1; cyc(); irq_done = 1'b0;
  endtask

  task automatic applyStimulus();
    int r, off;
    for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) ext_irq[i] = ~ext_irq[i];
    bus_we = 1'b0; bus_re = 1'b0;
    r = $urandom_range(0, 9);
    off = $urandom_range(0, 4);
    bus_addr = (off == 4) ? BASE + 32'h10 : BASE + 32'(off * 4);
    if ($urandom_range(0, 15) == 0) bus_addr = bus_addr + 32'd1;
    bus_wdata = $urandom;
    if (r < 2) bus_we = 1'b1;
    else if (r < 4) bus_re = 1'b1;
    irq_ack  = ($urandom_range(0, 3) == 0);
    irq_done = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    cyc(2);
    checkOutput("reset irq_req",   32'(irq_req), 32'd0);
    checkOutput("reset irq_cause", irq_cause,    32'd0);
    checkOutput("reset irq_id",    32'(irq_id),  32'd0);
    checkOutput("reset bus_rdata", bus_rdata,    32'd0);
    rst_n = 1'b1;
    cyc();

`ifdef IRQ_TIMER_EN
    busWrite(BASE + 32'h4, 32'd20);
    busWrite(BASE + 32'hC, 32'h8000_0000);
    waitReq("timer req", 40);
    checkOutput("timer cause", irq_cause, C_TMR);
    checkOutput("timer id", 32'(irq_id), 32'd0);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    checkOutput("timer ack drops req", 32'(irq_req), 32'd0);
    irq_done = 1'b1; cyc(); irq_done = 1'b0;
    cyc();
    checkOutput("timer reassert", 32'(irq_req), 32'd1);
    busWrite(BASE + 32'h4, 32'hFFFF_FFFF);
    cyc();
    checkOutput("timer withdraw", 32'(irq_req), 32'd0);
    busWrite(BASE + 32'hC, 32'h0);
`endif

    // Two lines rising together: lowest index first, then line 1
    busWrite(BASE + 32'hC, 32'h3);
    ext_irq = 4'b0011;
    cyc(3);
    checkOutput("ext latency early", 32'(irq_req), 32'd0);
    cyc();
    checkOutput("ext latency req", 32'(irq_req), 32'd1);
    checkOutput("ext first id", 32'(irq_id), 32'd0);
    checkOutput("ext cause", irq_cause, C_EXT);
    ext_irq = '0;
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    checkOutput("ack drops req", 32'(irq_req), 32'd0);
    busRead(BASE + 32'h8, rd);
    checkOutput("ack clears only bit0", rd, 32'h2);
    irq_done = 1'b1; cyc(); irq_done = 1'b0;
    cyc();
    checkOutput("second req", 32'(irq_req), 32'd1);
    checkOutput("second id", 32'(irq_id), 32'd1);
    serviceReq("second service");

    // Withdrawal by W1C, then W1C colliding with a fresh edge
    busWrite(BASE + 32'hC, 32'h4);
    ext_irq[2] = 1'b1;
    cyc(4);
    checkOutput("line2 req", 32'(irq_req), 32'd1);
    checkOutput("line2 id", 32'(irq_id), 32'd2);
    ext_irq[2] = 1'b0;
    busWrite(BASE + 32'h8, 32'h4);
    cyc();
    checkOutput("w1c withdraw", 32'(irq_req), 32'd0);
    ext_irq[2] = 1'b1;
    cyc(2);
    busWrite(BASE + 32'h8, 32'h4);
    ext_irq[2] = 1'b0;
    busRead(BASE + 32'h8, rd);
    checkOutput("set beats w1c", rd, 32'h4);
    serviceReq("line2 service");
    busWrite(BASE + 32'hC, 32'h0);

`ifdef IRQ_TIMER_EN
    ext_irq[3] = 1'b1;
    cyc(4);
    ext_irq[3] = 1'b0;
    busWrite(BASE + 32'h4, 32'h0);
    busWrite(BASE + 32'hC, 32'h8000_0008);
    cyc();
    checkOutput("prio req", 32'(irq_req), 32'd1);
    checkOutput("prio cause", irq_cause, C_EXT);
    checkOutput("prio id", 32'(irq_id), 32'd3);
    busWrite(BASE + 32'h4, 32'hFFFF_FFFF);
    checkOutput("cause stable", irq_cause, C_EXT);
    serviceReq("prio service");
    busWrite(BASE + 32'hC, 32'h0);

    busWrite(BASE + 32'h4, 32'd5);
    busWrite(BASE + 32'h0, 32'hFFFF_FFFE);
    cyc();
    busRead(BASE + 32'h0, rd);
    checkOutput("mtime max", rd, 32'hFFFF_FFFF);
    busRead(BASE + 32'h0, rd);
    checkOutput("mtime wrap", rd, 32'h0);
    busWrite(BASE + 32'hC, 32'h8000_0000);
    checkOutput("no req below cmp", 32'(irq_req), 32'd0);
    waitReq("req after wrap", 10);
    checkOutput("wrap cause", irq_cause, C_TMR);
    busWrite(BASE + 32'h4, 32'hFFFF_FFFF);
    cyc(2);
    busWrite(BASE + 32'hC, 32'h0);
`else
    busWrite(BASE + 32'h0, 32'h1234);
    busRead(BASE + 32'h0, rd);
    checkOutput("mtime absent", rd, 32'h0);
`endif

    // Asynchronous reset while the handler runs
    busWrite(BASE + 32'hC, 32'h8);
    ext_irq[3] = 1'b1;
    waitReq("line3 req", 20);
    ext_irq[3] = 1'b0;
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    busRead(BASE + 32'hC, rd);
    checkOutput("enable readback", rd, 32'h8);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async irq_req",   32'(irq_req), 32'd0);
    checkOutput("async irq_cause", irq_cause,    32'd0);
    checkOutput("async irq_id",    32'(irq_id),  32'd0);
    checkOutput("async bus_rdata", bus_rdata,    32'd0);
    cyc();
    rst_n = 1'b1;
    irq_done = 1'b1; cyc(); irq_done = 1'b0;
    cyc(2);
    checkOutput("done after reset", 32'(irq_req), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      cyc();
    end
    bus_we = 1'b0; bus_re = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
